mem_bus_responder: RTL and testbench

Memory-side endpoint of the shared 73-bit system bus: accepts cache-line read/write requests issued by the data cache's bus access units, performs the access on a 128-bit main-memory port, and returns the line to the requester over the bus. It is the responder for the initiator traffic carried on `BUS`/`req_d`/`grant_d`/`ack_d`/`releases_d`/`dest_d`. One request is in flight at a time.

---
 rtl/mem_resp_pkg.sv | 36 +++
 rtl/mem_resp_rxbuf.sv | 38 +++
 rtl/mem_bus_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory-side bus responder: FSM state encoding,
// bus beat field positions and line geometry.
package mem_resp_pkg;

  localparam int unsigned BUS_W          = 73;
  localparam int unsigned SRC_MSB        = 72;
  localparam int unsigned DEST_MSB       = 68;
  localparam int unsigned WRITE_BIT      = 64;
  localparam int unsigned ID_W           = 4;
  localparam int unsigned BEAT_W         = 64;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BEATS_PER_LINE = 2;
  localparam int unsigned LINE_W         = BEATS_PER_LINE * BEAT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_D0,
    S_RX_D1,
    S_ACCESS,
    S_REQ,
    S_TX0,
    S_TX1,
    S_WAIT_ACK
  } state_t;

  // Assemble one bus beat: {src, dest, write, payload}.
  function automatic logic [BUS_W-1:0] make_beat(
    input logic [ID_W-1:0]   src,
    input logic [ID_W-1:0]   dst,
    input logic              wr,
    input logic [BEAT_W-1:0] payload
  );
    return {src, dst, wr, payload};
  endfunction

endpackage

// File: rtl/mem_resp_rxbuf.sv
// Request capture registers: header fields (src, address, write) and the two
// write-data beats, each loaded under an FSM-driven enable.
module mem_resp_rxbuf
  import mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   src_in,
  input  logic              write_in,
  input  logic [BEAT_W-1:0] payload,
  input  logic              load_hdr,
  input  logic              load_d0,
  input  logic              load_d1,
  output logic [ID_W-1:0]   src,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [LINE_W-1:0] line
);

  // Field capture; data beats fill the line low half first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src   <= '0;
      addr  <= '0;
      write <= 1'b0;
      line  <= '0;
    end else begin
      if (load_hdr) begin
        src   <= src_in;
        addr  <= payload[ADDR_W-1:0];
        write <= write_in;
      end
      if (load_d0) line[BEAT_W-1:0]      <= payload;
      if (load_d1) line[LINE_W-1:BEAT_W] <= payload;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the 73-bit system bus. Accepts one cache-line
// read/write request at a time, performs it on the 128-bit memory port and
// returns the line (or a write ack) to the requester.
// Optional feature: MEM_RESP_WRITE_ACK_EN -- completed writes send a
// single-beat ack packet; otherwise writes finish silently.
module mem_bus_responder
  import mem_resp_pkg::*;
#(
  parameter logic [ID_W-1:0] MY_ID    = 4'd8,
  parameter int unsigned     ACK_WAIT = 15
)(
  input  logic              clk_bus,
  input  logic              clr,
  inout  logic [BUS_W-1:0]  BUS,
  input  logic              setReceiver,
  output logic              free_bau,
  output logic              req,
  input  logic              grant,
  input  logic              ack,
  output logic              bus_release,
  output logic [ID_W-1:0]   dest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              proto_err
);

  localparam int unsigned CNT_W = $clog2(ACK_WAIT + 1);

  state_t              state, next;
  logic                load_hdr, load_d0, load_d1;
  logic                drive, accept, timeout, collide, hit;
  logic [BEAT_W-1:0]   payload_tx;
  logic [ID_W-1:0]     rx_src;
  logic [ADDR_W-1:0]   rx_addr;
  logic                wr;
  logic [LINE_W-1:0]   rdata;
  logic [CNT_W-1:0]    cnt;

  assign hit = setReceiver && (BUS[DEST_MSB -: ID_W] == MY_ID);

  mem_resp_rxbuf u_rxbuf (
    .clk      (clk_bus),
    .rst_n    (clr),
    .src_in   (BUS[SRC_MSB -: ID_W]),
    .write_in (BUS[WRITE_BIT]),
    .payload  (BUS[BEAT_W-1:0]),
    .load_hdr (load_hdr),
    .load_d0  (load_d0),
    .load_d1  (load_d1),
    .src      (rx_src),
    .addr     (rx_addr),
    .write    (wr),
    .line     (mem_wdata)
  );

  assign dest     = rx_src;
  assign mem_addr = {rx_addr[ADDR_W-1:4], 4'b0000};
  assign free_bau = (state == S_IDLE);
  assign BUS      = drive ? make_beat(MY_ID, rx_src, wr, payload_tx) : 'z;

  // State, read-line capture, ack-wait counter, release pulse, sticky error.
  always_ff @(posedge clk_bus or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      rdata       <= '0;
      cnt         <= '0;
      bus_release <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= next;
      bus_release <= accept;
      proto_err   <= proto_err | collide | timeout;
      if (state == S_ACCESS && mem_ready && !wr) rdata <= mem_rdata;
      if (state == S_WAIT_ACK && !ack) cnt <= cnt + 1'b1;
      else                             cnt <= '0;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next       = state;
    load_hdr   = 1'b0;
    load_d0    = 1'b0;
    load_d1    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    req        = 1'b0;
    drive      = 1'b0;
    payload_tx = '0;
    accept     = 1'b0;
    timeout    = 1'b0;
    collide    = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          load_hdr = 1'b1;
          next     = BUS[WRITE_BIT] ? S_RX_D0 : S_ACCESS;
        end
      end
      S_RX_D0: begin
        if (setReceiver) begin
          load_d0 = 1'b1;
          next    = S_RX_D1;
        end
      end
      S_RX_D1: begin
        if (setReceiver) begin
          load_d1 = 1'b1;
          next    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        collide = hit;
        mem_rd  = !wr;
        mem_wr  = wr;
        if (mem_ready) begin
`ifdef MEM_RESP_WRITE_ACK_EN
          next = S_REQ;
`else
          next = wr ? S_IDLE : S_REQ;
`endif
        end
      end
      S_REQ: begin
        collide = hit;
        req     = 1'b1;
        if (grant) next = S_TX0;
      end
      S_TX0: begin
        collide    = hit;
        req        = 1'b1;
        drive      = 1'b1;
        payload_tx = wr ? {32'b0, rx_addr} : rdata[BEAT_W-1:0];
        if (!wr)     next = S_TX1;
        else if (ack) begin
          accept = 1'b1;
          next   = S_IDLE;
        end else     next = S_WAIT_ACK;
      end
      S_TX1: begin
        collide    = hit;
        req        = 1'b1;
        drive      = 1'b1;
        payload_tx = rdata[LINE_W-1:BEAT_W];
        if (ack) begin
          accept = 1'b1;
          next   = S_IDLE;
        end else next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        collide = hit;
        req     = 1'b1;
        if (ack) begin
          accept = 1'b1;
          next   = S_IDLE;
        end else if (cnt == CNT_W'(ACK_WAIT - 1)) begin
          // Give up on the receiver: flag it and hand the bus back anyway.
          timeout = 1'b1;
          accept  = 1'b1;
          next    = S_IDLE;
        end
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

  localparam logic [3:0]  ID = 4'd8;
  localparam int unsigned AW = 15;
`ifdef MEM_RESP_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic          clk_bus = 1'b0;
  logic          clr = 1'b0;
  logic          setReceiver = 1'b0;
  logic          grant = 1'b0;
  logic          ack = 1'b0;
  logic          mem_ready = 1'b0;
  logic [127:0]  mem_rdata = '0;
  logic          free_bau, req, bus_release, mem_rd, mem_wr, proto_err;
  logic [3:0]    dest;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [72:0]   bus_drv = '0;
  logic          bus_en = 1'b0;
  wire  [72:0]   BUS;

  assign BUS = bus_en ? bus_drv : 73'bz;

  always #5 clk_bus = ~clk_bus;

  mem_bus_responder #(.MY_ID(ID), .ACK_WAIT(AW)) dut (
    .clk_bus     (clk_bus),
    .clr         (clr),
    .BUS         (BUS),
    .setReceiver (setReceiver),
    .free_bau    (free_bau),
    .req         (req),
    .grant       (grant),
    .ack         (ack),
    .bus_release (bus_release),
    .dest        (dest),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .proto_err   (proto_err)
  );

  int checks = 0;
  int errors = 0;
  logic [72:0] exp_q[$];

  typedef struct {
    logic [3:0]   src;
    logic [31:0]  addr;
    logic         wr;
    logic [63:0]  d0;
    logic [63:0]  d1;
    logic [127:0] rdata;
    int unsigned  lat;
    logic         early_ack;
    logic [31:0]  exp_addr;
    logic [127:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] s, input logic [3:0] d, input logic w, input logic [63:0] p);
    bus_drv     = {s, d, w, p};
    bus_en      = 1'b1;
    setReceiver = 1'b1;
    tick();
    bus_en      = 1'b0;
    setReceiver = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] s, input logic [127:0] rd);
    logic [127:0] r;
    r = rd;
    exp_q.push_back({ID, s, 1'b0, r[63:0]});
    exp_q.push_back({ID, s, 1'b0, r[127:64]});
  endtask

  // Memory: strobe held for lat cycles, ready on the last one; ends at the
  // negedge of the first cycle after ACCESS.
  task automatic serve(input int unsigned lat, input logic [127:0] rd);
    for (int unsigned i = 0; i < lat; i++) begin
      @(negedge clk_bus);
      chk("strobe_held", {127'b0, mem_rd | mem_wr}, 128'd1);
      if (i == lat - 1) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk_bus);
    chk("strobe_off", {126'b0, mem_rd, mem_wr}, 128'd0);
  endtask

  // Called at negedge of the first REQ cycle.
  task automatic do_resp(input logic early, input int unsigned n_tx);
    chk("req_up", {127'b0, req}, 128'd1);
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    for (int unsigned i = 0; i < n_tx; i++) begin
      if (i == n_tx - 1 && early) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    if (!early) begin
      tick();
      @(negedge clk_bus);
      chk("wait_ack_no_release", {126'b0, bus_release, req}, 128'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    @(negedge clk_bus);
    chk("release_pulse", {125'b0, bus_release, req, free_bau}, 128'b101);
    tick();
    @(negedge clk_bus);
    chk("release_one_cycle", {127'b0, bus_release}, 128'd0);
  endtask

  task automatic run_vec(input vec_t v);
    if (!v.wr) push_read(v.src, v.rdata);
    else if (ACK_EN) exp_q.push_back({ID, v.src, 1'b1, 32'b0, v.addr});
    send_beat(v.src, ID, v.wr, {32'hCAFE_F00D, v.addr});
    @(negedge clk_bus);
    chk("busy_after_hdr", {127'b0, free_bau}, 128'd0);
    if (v.wr) begin
      send_beat(v.src, ID, 1'b0, v.d0);
      send_beat(v.src, ID, 1'b0, v.d1);
      @(negedge clk_bus);
      chk("mem_wdata", mem_wdata, v.exp_wdata);
    end
    chk("mem_addr", {96'b0, mem_addr}, {96'b0, v.exp_addr});
    chk("strobe_kind", {126'b0, mem_rd, mem_wr}, v.wr ? 128'b01 : 128'b10);
    serve(v.lat, v.rdata);
    if (!v.wr || ACK_EN) begin
      do_resp(v.early_ack, v.wr ? 1 : 2);
    end else begin
      chk("write_idle", {126'b0, free_bau, req}, 128'b10);
      repeat (3) begin
        tick();
        @(negedge clk_bus);
        chk("write_no_req", {127'b0, req}, 128'd0);
      end
    end
    chk("beats_consumed", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every beat the DUT drives must match the queue head.
  always @(negedge clk_bus) begin
    if (!bus_en && BUS !== 73'bz) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", BUS);
      end else begin
        chk("tx_beat", {55'b0, BUS}, {55'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic        seen;
    logic [127:0] r;

    vecs[0] = '{4'd2, 32'h0000_1234, 1'b0, 64'h0, 64'h0,
                128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB, 3, 1'b0, 32'h0000_1230, 128'h0};
    vecs[1] = '{4'd7, 32'h0000_0040, 1'b1, 64'h1111, 64'h2222,
                128'h0, 2, 1'b0, 32'h0000_0040, {64'h2222, 64'h1111}};
    vecs[2] = '{4'd5, 32'hFFFF_FFFF, 1'b0, 64'h0, 64'h0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 1'b1, 32'hFFFF_FFF0, 128'h0};
    vecs[3] = '{4'd1, 32'h8000_000C, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002,
                128'h0, 1, 1'b1, 32'h8000_0000, 128'hCAFE_F00D_0000_0002_DEAD_BEEF_0000_0001};
    vecs[4] = '{4'd15, 32'h0000_0ABC, 1'b0, 64'h0, 64'h0,
                128'h5555_5555_5555_5555_6666_6666_6666_6666, 4, 1'b0, 32'h0000_0AB0, 128'h0};

    // Reset values
    @(negedge clk_bus);
    chk("rst_flags", {124'b0, free_bau, req, bus_release, proto_err}, 128'b1000);
    chk("rst_mem", {126'b0, mem_rd, mem_wr}, 128'd0);
    chk("rst_dest", {124'b0, dest}, 128'd0);
    chk("rst_addr", {96'b0, mem_addr}, 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    chk("rst_bus_z", {127'b0, BUS === 73'bz}, 128'd1);
    @(posedge clk_bus);
    #1 clr = 1'b1;
    tick();

    // Foreign dest and stray grant are ignored
    send_beat(4'd2, 4'd3, 1'b0, 64'h1234);
    @(negedge clk_bus);
    chk("foreign_dest", {125'b0, free_bau, proto_err, mem_rd}, 128'b100);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    @(negedge clk_bus);
    chk("stray_grant", {126'b0, free_bau, req}, 128'b10);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    chk("no_err_after_table", {127'b0, proto_err}, 128'd0);

    // Busy collision during ACCESS
    r = 128'h0F0F_0F0F_0F0F_0F0F_1E1E_1E1E_1E1E_1E1E;
    push_read(4'd3, r);
    send_beat(4'd3, ID, 1'b0, 64'h500);
    send_beat(4'd9, ID, 1'b0, 64'h999);
    @(negedge clk_bus);
    chk("collide_err", {127'b0, proto_err}, 128'd1);
    chk("collide_addr", {96'b0, mem_addr}, 128'h500);
    chk("collide_dest", {124'b0, dest}, 128'd3);
    serve(2, r);
    do_resp(1'b0, 2);
    chk("collide_sticky", {127'b0, proto_err}, 128'd1);
    chk("collide_beats", exp_q.size(), 0);

    // Reset during TX0
    r = 128'h7777_7777_7777_7777_8888_8888_8888_8888;
    send_beat(4'd4, ID, 1'b0, 64'h700);
    serve(1, r);
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("tx0_before_reset", {55'b0, BUS}, {55'b0, ID, 4'd4, 1'b0, 64'h8888_8888_8888_8888});
    #1 clr = 1'b0;
    #1;
    chk("reset_bus_z", {127'b0, BUS === 73'bz}, 128'd1);
    chk("reset_flags", {124'b0, free_bau, req, bus_release, proto_err}, 128'b1000);
    @(posedge clk_bus);
    #1 clr = 1'b1;
    tick();
    @(negedge clk_bus);
    chk("reset_no_release", {126'b0, bus_release, free_bau}, 128'b01);

    // Ack timeout
    r = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    push_read(4'd6, r);
    send_beat(4'd6, ID, 1'b0, 64'h1000);
    serve(1, r);
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    tick();
    tick();
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_bus);
      if (bus_release) seen = 1'b1;
      else begin
        if (k == 0) chk("timeout_err_clear", {127'b0, proto_err}, 128'd0);
        k++;
        tick();
      end
    end
    chk("timeout_release_seen", {127'b0, seen}, 128'd1);
    chk("timeout_cycles", {96'b0, k}, {96'b0, AW});
    chk("timeout_flags", {125'b0, proto_err, free_bau, req}, 128'b110);
    tick();
    @(negedge clk_bus);
    chk("timeout_release_once", {127'b0, bus_release}, 128'd0);
    chk("final_beats", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
